// File: rtl/traffic_lights.sv
// Single-approach traffic-light controller: timed Moore FSM cycling RED -> GREEN -> YELLOW.
// Each phase holds for its timer value in clock cycles; lamp outputs are registered and one-hot.
module traffic_lights #(
  parameter int GREENTIMER  = 6,
  parameter int YELLOWTIMER = 2,
  parameter int REDTIMER    = 8
) (
  input  logic clk,
  input  logic rstn,
  output logic red,
  output logic green,
  output logic yellow
);

  // A zero (or negative) duration is clamped to a single-cycle phase.
  localparam int unsigned G_T = (GREENTIMER  < 1) ? 1 : GREENTIMER;
  localparam int unsigned Y_T = (YELLOWTIMER < 1) ? 1 : YELLOWTIMER;
  localparam int unsigned R_T = (REDTIMER    < 1) ? 1 : REDTIMER;

  localparam int unsigned MAX_GY = (G_T > Y_T) ? G_T : Y_T;
  localparam int unsigned MAX_T  = (MAX_GY > R_T) ? MAX_GY : R_T;
  localparam int          CNT_W  = (MAX_T <= 1) ? 1 : $clog2(MAX_T);

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_T - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_T - 1);

  localparam logic [1:0] S_RED    = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       phase_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] last_cnt;
  logic             legal;

  always_comb begin
    state_nxt = S_RED;
    cnt_nxt   = '0;
    phase_nxt = S_RED;
    last_cnt  = R_LAST;
    legal     = 1'b1;
    case (state)
      S_RED: begin
        last_cnt  = R_LAST;
        phase_nxt = S_GREEN;
      end
      S_GREEN: begin
        last_cnt  = G_LAST;
        phase_nxt = S_YELLOW;
      end
      S_YELLOW: begin
        last_cnt  = Y_LAST;
        phase_nxt = S_RED;
      end
      default: legal = 1'b0;
    endcase
    // The illegal encoding keeps the defaults: back to red with the counter cleared.
    if (legal) begin
      if (cnt == last_cnt) begin
        state_nxt = phase_nxt;
        cnt_nxt   = '0;
      end else begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
      end
    end
  end

  // Lamps are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_RED;
      cnt    <= '0;
      red    <= 1'b1;
      green  <= 1'b0;
      yellow <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      red    <= (state_nxt == S_RED);
      green  <= (state_nxt == S_GREEN);
      yellow <= (state_nxt == S_YELLOW);
    end
  end

endmodule

// File: tb/tb_traffic_lights.sv
// Scoreboard bench for traffic_lights: defaults, all-1 timers and a 20-cycle red phase.
// Stimulus pushes expected lamp vectors per cycle; a negedge monitor pops and compares.
module tb_traffic_lights;

  logic clk;
  logic rstn;
  logic d0_red, d0_green, d0_yellow;
  logic d1_red, d1_green, d1_yellow;
  logic d2_red, d2_green, d2_yellow;

  int checks;
  int errors;
  int unsigned n;
  logic [8:0] exp_q[$];
  bit done;

  traffic_lights d0 (
    .clk(clk), .rstn(rstn), .red(d0_red), .green(d0_green), .yellow(d0_yellow)
  );

  traffic_lights #(.GREENTIMER(1), .YELLOWTIMER(1), .REDTIMER(1)) d1 (
    .clk(clk), .rstn(rstn), .red(d1_red), .green(d1_green), .yellow(d1_yellow)
  );

  traffic_lights #(.GREENTIMER(6), .YELLOWTIMER(2), .REDTIMER(20)) d2 (
    .clk(clk), .rstn(rstn), .red(d2_red), .green(d2_green), .yellow(d2_yellow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position within the period since reset release; {red, green, yellow}.
  function automatic logic [2:0] lamp(input int unsigned k, input int unsigned r,
                                      input int unsigned g, input int unsigned y);
    int unsigned pos;
    pos = k % (r + g + y);
    if (pos < r)          return 3'b100;
    else if (pos < r + g) return 3'b010;
    else                  return 3'b001;
  endfunction

  // One clock cycle of stimulus; drop_rst pulls rstn low between edges.
  task automatic cycle(input bit drop_rst);
    @(posedge clk);
    #2;
    if (drop_rst) rstn = 1'b0;
    if (!rstn) begin
      exp_q.push_back(9'b100_100_100);
    end else begin
      n = n + 1;
      exp_q.push_back({lamp(n, 8, 6, 2), lamp(n, 1, 1, 1), lamp(n, 20, 6, 2)});
    end
  endtask

  task automatic release_rst();
    rstn = 1'b1;
    n = 0;
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({d0_red, d0_green, d0_yellow} !== e[8:6]) begin
          errors++;
          $display("FAIL lamps_default t=%0t actual=%b required=%b", $time,
                   {d0_red, d0_green, d0_yellow}, e[8:6]);
        end
        checks++;
        if ({d1_red, d1_green, d1_yellow} !== e[5:3]) begin
          errors++;
          $display("FAIL lamps_t1 t=%0t actual=%b required=%b", $time,
                   {d1_red, d1_green, d1_yellow}, e[5:3]);
        end
        checks++;
        if ({d2_red, d2_green, d2_yellow} !== e[2:0]) begin
          errors++;
          $display("FAIL lamps_red20 t=%0t actual=%b required=%b", $time,
                   {d2_red, d2_green, d2_yellow}, e[2:0]);
        end
        checks++;
        if (d2.cnt > 5'd19) begin
          errors++;
          $display("FAIL cnt_bound_red20 t=%0t actual=%0d required<=19", $time, d2.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    n = 0;
    done = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) cycle(1'b0);
    release_rst();
    // Ten default periods plus margin; d1 and d2 run alongside.
    for (int i = 0; i < 170; i++) cycle(1'b0);
    // Advance into the middle of the default green phase, then reset asynchronously.
    while ((n + 1) % 16 != 10) cycle(1'b0);
    cycle(1'b1);
    for (int i = 0; i < 49; i++) cycle(1'b0);
    release_rst();
    for (int i = 0; i < 60; i++) cycle(1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
